// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared encodings for the execute/memory slice of the single-cycle MIPS CPU:
//   - ALU-op classes from the main control unit
//   - R-type funct field values
//   - 4-bit operation codes understood by the main ALU
// -----------------------------------------------------------------------------
package mips_pkg;

  // ALU-op class driven by the main control unit.
  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,  // lw / sw: address add
    ALUOP_BEQ   = 2'b01,  // beq: compare by subtract
    ALUOP_RTYPE = 2'b10,  // R-type: look at funct
    ALUOP_RSVD  = 2'b11   // unused encoding
  } alu_op_e;

  // R-type funct field (instruction[5:0]).
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  // Operation code presented to the main ALU.
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_INV = 4'b1111;  // ALU treats this as a no-op

endpackage

// File: rtl/mips_alu_ctrl_dmem_if.sv
// -----------------------------------------------------------------------------
// mips_alu_ctrl_dmem_if
// Signal bundle between the CPU datapath/control and the execute/memory slice.
//   master : control unit / datapath side (drives opcode, branch, memory req)
//   slave  : mips_alu_ctrl_dmem (returns operation, pc_src, read_data)
// Signals:
//   alu_op[1:0], funct[5:0]      -> operation[3:0]
//   branch, zero                 -> pc_src
//   addr[31:0], write_data[31:0],
//   mem_read, mem_write          -> read_data[31:0]
// -----------------------------------------------------------------------------
interface mips_alu_ctrl_dmem_if;

  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [3:0]  operation;
  logic        branch;
  logic        zero;
  logic        pc_src;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] read_data;

  modport master (
    output alu_op, funct, branch, zero, addr, write_data, mem_read, mem_write,
    input  operation, pc_src, read_data
  );

  modport slave (
    input  alu_op, funct, branch, zero, addr, write_data, mem_read, mem_write,
    output operation, pc_src, read_data
  );

endinterface

// File: rtl/mips_dmem_array.sv
// -----------------------------------------------------------------------------
// mips_dmem_array
// Word-addressed data memory: DEPTH x 32-bit words, synchronous write,
// combinational read, asynchronous clear of every word on reset.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   index           : word index (already extracted from the byte address)
//   write_data      : full-word store data
//   mem_read        : read enable; read_data is 0 when low
//   mem_write       : write enable, sampled on posedge clk
//   read_data       : combinational load data
// -----------------------------------------------------------------------------
module mips_dmem_array #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] index,
  input  logic [31:0]       write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  output logic [31:0]       read_data
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array must clear asynchronously on reset, so it is built from
  // resettable flops rather than a RAM macro; a RAM cannot be cleared in one go.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_write) begin
      // NOTE: non-blocking update, so a same-edge combinational read still
      // sees the old word until the edge has passed (no bypass).
      mem[index] <= write_data;
    end
  end

  // Reset forces the output low directly instead of relying on the cleared
  // array, so read_data is 0 for the whole reset pulse regardless of timing.
  assign read_data = (mem_read && !reset) ? mem[index] : 32'h0;

endmodule

// File: rtl/mips_alu_ctrl_dmem.sv
// -----------------------------------------------------------------------------
// mips_alu_ctrl_dmem
// Execute/memory-stage slice of the single-cycle MIPS CPU:
//   - ALU control decode: alu_op + funct -> 4-bit operation (combinational)
//   - Branch select:      pc_src = branch & zero (combinational, reset-free)
//   - Data memory:        word addressed by addr[ADDR_W+1:2], upper bits and
//                         byte offset ignored (addresses wrap mod DEPTH*4)
// Ports:
//   clk, reset : single clock, asynchronous active-high reset (memory only)
//   bus        : mips_alu_ctrl_dmem_if.slave carrying all datapath signals
// -----------------------------------------------------------------------------
module mips_alu_ctrl_dmem
  import mips_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_alu_ctrl_dmem_if.slave   bus
);

  logic [3:0]        operation;
  logic [ADDR_W-1:0] index;
  logic [31:0]       read_data;

  // ---------------------------------------------------------------------------
  // ALU control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assigned first so every path drives operation; without it
    // a missed case arm would infer a latch.
    operation = OP_INV;
    case (alu_op_e'(bus.alu_op))
      ALUOP_MEM:   operation = OP_ADD;
      ALUOP_BEQ:   operation = OP_SUB;
      ALUOP_RTYPE: begin
        case (bus.funct)
          FN_ADD:  operation = OP_ADD;
          FN_SUB:  operation = OP_SUB;
          FN_AND:  operation = OP_AND;
          FN_OR:   operation = OP_OR;
          FN_SLT:  operation = OP_SLT;
          FN_NOR:  operation = OP_NOR;
          FN_SLL:  operation = OP_SLL;
          FN_SRL:  operation = OP_SRL;
          default: operation = OP_INV;
        endcase
      end
      default:     operation = OP_INV;
    endcase
  end

  assign bus.operation = operation;

  // ---------------------------------------------------------------------------
  // Branch select
  // ---------------------------------------------------------------------------
  assign bus.pc_src = bus.branch & bus.zero;

  // ---------------------------------------------------------------------------
  // Data memory
  // ---------------------------------------------------------------------------
  // Byte offset and bits above the array size are dropped on purpose.
  assign index = bus.addr[ADDR_W+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

  mips_dmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk        (clk),
    .reset      (reset),
    .index      (index),
    .write_data (bus.write_data),
    .mem_read   (bus.mem_read),
    .mem_write  (bus.mem_write),
    .read_data  (read_data)
  );

  assign bus.read_data = read_data;

endmodule

// File: tb/tb_mips_alu_ctrl_dmem.sv
// -----------------------------------------------------------------------------
// tb_mips_alu_ctrl_dmem
// Directed self-checking bench for mips_alu_ctrl_dmem (DEPTH = 256).
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the input change or after the rising edge.
// -----------------------------------------------------------------------------
module tb_mips_alu_ctrl_dmem;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  mips_alu_ctrl_dmem_if bus ();

  mips_alu_ctrl_dmem #(
    .DEPTH  (256),
    .ADDR_W (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full-word store: set up on the falling edge, commit on the next rising edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr       = a;
    bus.write_data = d;
    bus.mem_write  = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_write  = 1'b0;
  endtask

  task automatic check_read(input string name, input logic [31:0] a,
                            input logic [31:0] exp);
    bus.addr     = a;
    bus.mem_read = 1'b1;
    #1;
    tests++;
    if (bus.read_data !== exp) begin
      fails++;
      $display("FAIL %s: read_data got %h expected %h", name, bus.read_data, exp);
    end
  endtask

  task automatic test_reset();
    // reset is already high from time 0
    bus.mem_read = 1'b1;
    bus.addr     = 32'h0;
    #1;
    tests++;
    if (bus.read_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_read: read_data got %h expected %h", bus.read_data, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    check_read("post_reset_word0", 32'h0, 32'h0);
  endtask

  task automatic test_decode();
    logic [5:0] fn_tbl  [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                 6'b101010, 6'b100111, 6'b000000, 6'b000010,
                                 6'b111111, 6'b000001};
    logic [3:0] exp_tbl [10] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                                 4'b0111, 4'b1100, 4'b1000, 4'b1001,
                                 4'b1111, 4'b1111};
    logic [1:0] op_tbl  [3]  = '{2'b00, 2'b01, 2'b11};
    logic [3:0] opx_tbl [3]  = '{4'b0010, 4'b0110, 4'b1111};
    // Non-R-type classes must ignore funct (use an R-type funct as a decoy).
    for (int i = 0; i < 3; i++) begin
      bus.alu_op = op_tbl[i];
      bus.funct  = 6'b100100;
      #1;
      tests++;
      if (bus.operation !== opx_tbl[i]) begin
        fails++;
        $display("FAIL decode_aluop%0d: operation got %b expected %b",
                 i, bus.operation, opx_tbl[i]);
      end
    end
    bus.alu_op = 2'b10;
    for (int i = 0; i < 10; i++) begin
      bus.funct = fn_tbl[i];
      #1;
      tests++;
      if (bus.operation !== exp_tbl[i]) begin
        fails++;
        $display("FAIL decode_funct_%b: operation got %b expected %b",
                 fn_tbl[i], bus.operation, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_branch();
    for (int i = 0; i < 4; i++) begin
      bus.branch = i[1];
      bus.zero   = i[0];
      #1;
      tests++;
      if (bus.pc_src !== (i == 3)) begin
        fails++;
        $display("FAIL branch_%0d%0d: pc_src got %b expected %b",
                 i[1], i[0], bus.pc_src, (i == 3));
      end
    end
  endtask

  task automatic test_write_read();
    do_write(32'h10, 32'hDEADBEEF);
    check_read("rd_aligned",    32'h10,  32'hDEADBEEF);
    check_read("rd_misaligned", 32'h13,  32'hDEADBEEF);
    check_read("rd_wrap",       32'h410, 32'hDEADBEEF);
    check_read("rd_neighbor",   32'h14,  32'h0);
    bus.addr     = 32'h10;
    bus.mem_read = 1'b0;
    #1;
    tests++;
    if (bus.read_data !== 32'h0) begin
      fails++;
      $display("FAIL rd_disabled: read_data got %h expected %h", bus.read_data, 32'h0);
    end
  endtask

  task automatic test_read_during_write();
    do_write(32'h20, 32'h1);
    @(negedge clk);
    bus.addr       = 32'h20;
    bus.write_data = 32'h2;
    bus.mem_write  = 1'b1;
    bus.mem_read   = 1'b1;
    #1;
    tests++;
    if (bus.read_data !== 32'h1) begin
      fails++;
      $display("FAIL rdw_before_edge: read_data got %h expected %h", bus.read_data, 32'h1);
    end
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    tests++;
    if (bus.read_data !== 32'h2) begin
      fails++;
      $display("FAIL rdw_after_edge: read_data got %h expected %h", bus.read_data, 32'h2);
    end
  endtask

  task automatic test_async_reset();
    do_write(32'h0, 32'h11111111);
    do_write(32'h4, 32'h22222222);
    do_write(32'h8, 32'h33333333);
    check_read("pre_reset_word4", 32'h4, 32'h22222222);
    // Pulse reset between edges, with a write pending across a rising edge.
    @(negedge clk);
    #2;
    bus.addr       = 32'h0;
    bus.mem_read   = 1'b1;
    bus.write_data = 32'hCAFEF00D;
    bus.mem_write  = 1'b1;
    reset          = 1'b1;
    #1;
    tests++;
    if (bus.read_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_immediate: read_data got %h expected %h", bus.read_data, 32'h0);
    end
    // Combinational paths keep tracking inputs while reset is high.
    bus.alu_op = 2'b10;
    bus.funct  = 6'b101010;
    bus.branch = 1'b1;
    bus.zero   = 1'b1;
    #1;
    tests++;
    if (bus.operation !== 4'b0111 || bus.pc_src !== 1'b1) begin
      fails++;
      $display("FAIL comb_in_reset: operation/pc_src got %b/%b expected %b/%b",
               bus.operation, bus.pc_src, 4'b0111, 1'b1);
    end
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_read("cleared_word0", 32'h0, 32'h0);
    check_read("cleared_word4", 32'h4, 32'h0);
    check_read("cleared_word8", 32'h8, 32'h0);
  endtask

  task automatic test_reset_release();
    @(negedge clk);
    reset = 1'b1;
    #2;
    bus.branch = 1'b0;
    #1;
    tests++;
    if (bus.pc_src !== 1'b0) begin
      fails++;
      $display("FAIL pc_src_in_reset: pc_src got %b expected %b", bus.pc_src, 1'b0);
    end
    // Release with a write already set up; it must land on the very next edge.
    @(negedge clk);
    bus.addr       = 32'h40;
    bus.write_data = 32'hA5A55A5A;
    bus.mem_write  = 1'b1;
    reset          = 1'b0;
    @(posedge clk);
    #1;
    bus.mem_write = 1'b0;
    check_read("first_write_after_release", 32'h40, 32'hA5A55A5A);
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    reset          = 1'b1;
    bus.alu_op     = 2'b00;
    bus.funct      = 6'b0;
    bus.branch     = 1'b0;
    bus.zero       = 1'b0;
    bus.addr       = 32'h0;
    bus.write_data = 32'h0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;

    test_reset();
    test_decode();
    test_branch();
    test_write_read();
    test_read_during_write();
    test_async_reset();
    test_reset_release();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation time got %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
